note_synth: RTL and testbench
=============================

NOTE_SYNTH -- requirements
Module: note_synth

Interface
REQ-001 Parameter: CLK_HZ, default 50000000, system clock frequency used to build the half-period table.
REQ-002 Parameter: AMPLITUDE, default 10000000, positive magnitude of the square-wave sample.
REQ-003 Parameter: RELEASE_SAMPLES, default 2048, number of samples per release step.
REQ-004 Port: clock  input  1  system clock; all logic SHALL be on its rising edge.
REQ-005 Port: resetn  input  1  reset; SHALL be synchronous and active-low.
REQ-006 Port: enable  input  1  note gate, driven by the upstream stone-play stage's go level.
REQ-007 Port: sound  input  6  note code from the upstream stage.
REQ-008 Port: sample_req  input  1  codec ready-for-sample strobe.
REQ-009 Port: sample_out  output  32  signed two's-complement audio sample.
REQ-010 Port: sample_valid  output  1  one-cycle strobe qualifying sample_out.
REQ-011 Port: busy  output  1  high in any state other than IDLE.

Function
REQ-012 The FSM SHALL have three states: IDLE, PLAY and RELEASE.
REQ-013 IDLE->PLAY SHALL occur on a rising edge of enable (enable=1, previous-cycle enable=0); sound SHALL be latched in that cycle.
REQ-014 Changes on sound while in PLAY or RELEASE SHALL be ignored until the next IDLE->PLAY transition.
REQ-015 PLAY->RELEASE SHALL occur on the cycle enable is sampled 0.
REQ-016 RELEASE->PLAY SHALL occur on an enable rising edge; the new code is latched, envelope restored to full, phase=0, counter=0.
REQ-017 Codes 0..47 SHALL map to equal-tempered notes C3..B6.
REQ-018 For codes 0..47, half_period SHALL be round(CLK_HZ/(2*f)) from a constant 48-entry table of 18-bit values; code 9 (A3) SHALL give 113636 and code 21 (A4) SHALL give 56818.
REQ-019 Codes 48..63 (including 6'h3F) SHALL be rests: the FSM still runs, but the sample is 0.
REQ-020 An 18-bit counter SHALL increment every cycle in PLAY/RELEASE; at half_period-1 it SHALL wrap to 0 and toggle phase.
REQ-021 The counter and phase SHALL be held at 0 in IDLE.
REQ-022 The sample value SHALL be +amp when phase=0 and -amp when phase=1; in IDLE or on a rest code, the sample value SHALL be 0.
REQ-023 amp SHALL equal AMPLITUDE >> shift, where shift is 0 in PLAY.
REQ-024 On a cycle with sample_req=1, the sample value SHALL be registered into sample_out, and sample_valid SHALL be 1 on the next cycle only (latency 1).
REQ-025 sample_valid SHALL be 0 in all other cycles; sample_out SHALL hold its value between strobes.
REQ-026 If sample_req is held high, one strobe SHALL issue per cycle.
REQ-027 In RELEASE, shift SHALL increment after every RELEASE_SAMPLES issued samples.
REQ-028 When shift would reach 8, RELEASE->IDLE SHALL occur.
REQ-029 Simultaneous enable rising edge and release-step completion: the enable rising edge SHALL win.

Reset
REQ-030 While resetn=0 at a clock edge: state=IDLE, sample_out=0, sample_valid=0, busy=0, counter=0, phase=0, shift=0, latched code=6'h3F, previous-enable register=0.
REQ-031 Reset asserted mid-note SHALL abort the note with no further sample_valid strobe.

Configuration
REQ-032 Macro NOTE_SYNTH_RELEASE_EN SHALL control the release envelope.
REQ-033 With NOTE_SYNTH_RELEASE_EN defined: RELEASE state and envelope behave per REQ-012 to REQ-029.
REQ-034 Without NOTE_SYNTH_RELEASE_EN: RELEASE is not built, enable=0 in PLAY goes directly to IDLE, the next sample is 0, and shift is constant 0.

Verification
REQ-035 Reset then enable rise with sound=21, sample_req every 1136 cycles -> sample_out alternates +10000000/-10000000, with phase toggles 56818 cycles apart; busy=1.
REQ-036 sound=6'h3F, enable pulse, sample_req held -> sample_out=0 on every strobe, busy=1 during the note.
REQ-037 sound changes 9->21 mid-PLAY -> period remains 113636 cycles per half-wave.
REQ-038 With NOTE_SYNTH_RELEASE_EN and RELEASE_SAMPLES=4, drop enable -> magnitudes 10000000, 5000000, ... in groups of 4 samples; IDLE after shift 7 group; busy=0.
REQ-039 resetn=0 for one cycle mid-PLAY -> next cycle: all outputs 0, state IDLE, no strobe despite sample_req=1.
REQ-040 Without NOTE_SYNTH_RELEASE_EN, drop enable -> next strobe sample_out=0, busy=0 one cycle after enable is sampled low.

Source files
------------

// File: rtl/note_synth.sv
// Square-wave note generator: 48-note half-period table, codec sample strobes,
// optional 8-step release envelope built only when NOTE_SYNTH_RELEASE_EN is defined.
module note_synth #(
    parameter int CLK_HZ          = 50000000,
    parameter int AMPLITUDE       = 10000000,
    parameter int RELEASE_SAMPLES = 2048
) (
    input  logic        clock,
    input  logic        resetn,
    input  logic        enable,
    input  logic [5:0]  sound,
    input  logic        sample_req,
    output logic [31:0] sample_out,
    output logic        sample_valid,
    output logic        busy
);

`ifdef NOTE_SYNTH_RELEASE_EN
    typedef enum logic [1:0] {IDLE, PLAY, RELEASE} state_t;
    localparam int REL_W = $clog2(RELEASE_SAMPLES + 1);
`else
    typedef enum logic [1:0] {IDLE, PLAY} state_t;
`endif

    localparam logic [31:0] AMP = 32'(AMPLITUDE);

    // Octave-3 frequencies in units of 0.1 mHz; higher octaves double.
    function automatic longint base_freq(input int n);
        case (n)
            0:       base_freq = 1308128;
            1:       base_freq = 1385913;
            2:       base_freq = 1468324;
            3:       base_freq = 1555635;
            4:       base_freq = 1648138;
            5:       base_freq = 1746141;
            6:       base_freq = 1849972;
            7:       base_freq = 1959977;
            8:       base_freq = 2076523;
            9:       base_freq = 2200000;
            10:      base_freq = 2330819;
            default: base_freq = 2469417;
        endcase
    endfunction

    function automatic logic [47:0][17:0] build_tab();
        logic [47:0][17:0] tab;
        longint num, den;
        num = longint'(CLK_HZ) * 64'sd10000;
        for (int i = 0; i < 48; i++) begin
            den    = 2 * base_freq(i % 12) * (64'sd1 <<< (i / 12));
            tab[i] = 18'((num + den / 2) / den);
        end
        return tab;
    endfunction

    localparam logic [47:0][17:0] HALF_TAB = build_tab();

    state_t      state_q, state_d;
    logic        en_prev_q, en_prev_d;
    logic [5:0]  code_q, code_d;
    logic [17:0] cnt_q, cnt_d;
    logic        phase_q, phase_d;
    logic [31:0] sample_out_q, sample_out_d;
    logic        sample_valid_q, sample_valid_d;
    logic [2:0]  shift;
`ifdef NOTE_SYNTH_RELEASE_EN
    logic [2:0]       shift_q, shift_d;
    logic [REL_W-1:0] rel_cnt_q, rel_cnt_d;
    assign shift = shift_q;
`else
    assign shift = 3'd0;
`endif

    logic        rise, rest;
    logic [17:0] half;
    logic [31:0] amp, sample_val;

    always_comb begin
        rise       = enable & ~en_prev_q;
        rest       = (code_q >= 6'd48);
        half       = rest ? 18'h3FFFF : HALF_TAB[code_q];
        amp        = AMP >> shift;
        sample_val = (state_q == IDLE || rest) ? 32'd0 : (phase_q ? -amp : amp);

        state_d        = state_q;
        en_prev_d      = enable;
        code_d         = code_q;
        cnt_d          = cnt_q;
        phase_d        = phase_q;
        sample_valid_d = sample_req;
        sample_out_d   = sample_req ? sample_val : sample_out_q;
`ifdef NOTE_SYNTH_RELEASE_EN
        shift_d   = shift_q;
        rel_cnt_d = rel_cnt_q;
`endif

        if (state_q != IDLE) begin
            if (cnt_q == half - 18'd1) begin
                cnt_d   = 18'd0;
                phase_d = ~phase_q;
            end else begin
                cnt_d = cnt_q + 18'd1;
            end
        end

        case (state_q)
            IDLE: begin
                cnt_d   = 18'd0;
                phase_d = 1'b0;
                if (rise) begin
                    state_d = PLAY;
                    code_d  = sound;
                end
            end
            PLAY: begin
                if (!enable) begin
`ifdef NOTE_SYNTH_RELEASE_EN
                    state_d   = RELEASE;
                    shift_d   = 3'd0;
                    rel_cnt_d = '0;
`else
                    state_d = IDLE;
                    cnt_d   = 18'd0;
                    phase_d = 1'b0;
`endif
                end
            end
`ifdef NOTE_SYNTH_RELEASE_EN
            RELEASE: begin
                // A fresh note-on takes priority over an envelope step landing this cycle.
                if (rise) begin
                    state_d   = PLAY;
                    code_d    = sound;
                    shift_d   = 3'd0;
                    rel_cnt_d = '0;
                    cnt_d     = 18'd0;
                    phase_d   = 1'b0;
                end else if (sample_req) begin
                    if (rel_cnt_q == REL_W'(RELEASE_SAMPLES - 1)) begin
                        rel_cnt_d = '0;
                        if (shift_q == 3'd7) begin
                            state_d = IDLE;
                            shift_d = 3'd0;
                            cnt_d   = 18'd0;
                            phase_d = 1'b0;
                        end else begin
                            shift_d = shift_q + 3'd1;
                        end
                    end else begin
                        rel_cnt_d = rel_cnt_q + REL_W'(1);
                    end
                end
            end
`endif
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (!resetn) begin
            state_q        <= IDLE;
            en_prev_q      <= 1'b0;
            code_q         <= 6'h3F;
            cnt_q          <= 18'd0;
            phase_q        <= 1'b0;
            sample_out_q   <= 32'd0;
            sample_valid_q <= 1'b0;
`ifdef NOTE_SYNTH_RELEASE_EN
            shift_q        <= 3'd0;
            rel_cnt_q      <= '0;
`endif
        end else begin
            state_q        <= state_d;
            en_prev_q      <= en_prev_d;
            code_q         <= code_d;
            cnt_q          <= cnt_d;
            phase_q        <= phase_d;
            sample_out_q   <= sample_out_d;
            sample_valid_q <= sample_valid_d;
`ifdef NOTE_SYNTH_RELEASE_EN
            shift_q        <= shift_d;
            rel_cnt_q      <= rel_cnt_d;
`endif
        end
    end

    assign sample_out   = sample_out_q;
    assign sample_valid = sample_valid_q;
    assign busy         = (state_q != IDLE);

endmodule

// File: tb/tb_note_synth.sv
// Directed bench for note_synth at a scaled clock (CLK_HZ=500000) so half-periods stay short.
module tb_note_synth;
    localparam logic [31:0] AMP = 32'd10000000;

    logic        clock = 1'b0;
    logic        resetn, enable, sample_req;
    logic [5:0]  sound;
    logic [31:0] sample_out;
    logic        sample_valid, busy;
    int          n_chk = 0, n_pass = 0;

    note_synth #(.CLK_HZ(500000), .AMPLITUDE(10000000), .RELEASE_SAMPLES(4)) dut (
        .clock(clock), .resetn(resetn), .enable(enable), .sound(sound),
        .sample_req(sample_req), .sample_out(sample_out),
        .sample_valid(sample_valid), .busy(busy)
    );

    always #5 clock = ~clock;

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0d (0x%08h) expected %0d (0x%08h)", tag, got, got, exp, exp);
    endtask

    // Length in cycles of one full constant-sign run of sample_out, with sample_req held.
    task automatic meas_half(input string tag, input int exp);
        logic s0;
        int   n;
        s0 = sample_out[31];
        n  = 0;
        while (sample_out[31] == s0 && n < 5000) begin tick(); n++; end
        s0 = sample_out[31];
        n  = 0;
        while (sample_out[31] == s0 && n < 5000) begin tick(); n++; end
        chk(tag, n, exp);
        chk({tag, "_mag"}, sample_out, sample_out[31] ? -AMP : AMP);
    endtask

    task automatic go_idle(input string tag);
        int n;
        enable     = 1'b0;
        sample_req = 1'b1;
        n = 0;
        tick();
        while (busy && n < 500) begin tick(); n++; end
        chk(tag, {31'd0, busy}, 32'd0);
        sample_req = 1'b0;
        tick();
    endtask

    task automatic start_note(input logic [5:0] code);
        sound  = code;
        enable = 1'b1;
        tick();
    endtask

    logic [31:0] mag;

    initial begin
        resetn = 1'b0; enable = 1'b0; sample_req = 1'b0; sound = 6'd0;
        tick(); tick();
        resetn = 1'b1;
        tick();
        chk("rst_out", sample_out, 32'd0);
        chk("rst_vld", {31'd0, sample_valid}, 32'd0);
        chk("rst_busy", {31'd0, busy}, 32'd0);

        // Strobe in IDLE: zero sample, one-cycle valid
        sample_req = 1'b1;
        tick();
        chk("idle_vld", {31'd0, sample_valid}, 32'd1);
        chk("idle_out", sample_out, 32'd0);
        sample_req = 1'b0;
        tick();
        chk("idle_vld_drop", {31'd0, sample_valid}, 32'd0);

        // A4, sound change during PLAY must be ignored
        start_note(6'd21);
        chk("a4_busy", {31'd0, busy}, 32'd1);
        sound      = 6'd5;
        sample_req = 1'b1;
        tick();
        chk("a4_vld", {31'd0, sample_valid}, 32'd1);
        chk("a4_first", sample_out, AMP);
        meas_half("a4_half", 568);

        enable = 1'b0;
        tick();
`ifdef NOTE_SYNTH_RELEASE_EN
        chk("rel_busy", {31'd0, busy}, 32'd1);
        for (int i = 0; i < 32; i++) begin
            tick();
            mag = sample_out[31] ? -sample_out : sample_out;
            chk($sformatf("rel_mag%0d", i), mag, AMP >> (i / 4));
        end
        chk("rel_done_busy", {31'd0, busy}, 32'd0);
        tick();
        chk("rel_done_out", sample_out, 32'd0);
`else
        chk("off_busy", {31'd0, busy}, 32'd0);
        tick();
        chk("off_out", sample_out, 32'd0);
`endif
        go_idle("idle_a4");

        // A3 with code switched to 21 mid-note
        start_note(6'd9);
        sample_req = 1'b1;
        sound      = 6'd21;
        tick();
        meas_half("a3_half", 1136);
        go_idle("idle_a3");

        // Table ends: B6 (code 47) and C3 (code 0)
        start_note(6'd47);
        sample_req = 1'b1;
        tick();
        meas_half("b6_half", 127);
        go_idle("idle_b6");
        start_note(6'd0);
        sample_req = 1'b1;
        tick();
        meas_half("c3_half", 1911);
        go_idle("idle_c3");

        // Rest codes
        start_note(6'h3F);
        chk("rest63_busy", {31'd0, busy}, 32'd1);
        sample_req = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            chk($sformatf("rest63_out%0d", i), sample_out, 32'd0);
        end
        go_idle("idle_r63");
        start_note(6'd48);
        chk("rest48_busy", {31'd0, busy}, 32'd1);
        sample_req = 1'b1;
        tick(); tick();
        chk("rest48_out", sample_out, 32'd0);
        go_idle("idle_r48");

        // Reset mid-PLAY
        start_note(6'd21);
        sample_req = 1'b1;
        tick(); tick(); tick();
        chk("pre_rst_out", sample_out, AMP);
        resetn = 1'b0;
        enable = 1'b0;
        tick();
        chk("mid_rst_out", sample_out, 32'd0);
        chk("mid_rst_vld", {31'd0, sample_valid}, 32'd0);
        chk("mid_rst_busy", {31'd0, busy}, 32'd0);
        resetn     = 1'b1;
        sample_req = 1'b0;
        tick();
        chk("post_rst_vld", {31'd0, sample_valid}, 32'd0);
        chk("post_rst_busy", {31'd0, busy}, 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
